// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction ROM read port plus the core-facing head/control signals.
// The fetch queue uses the master modport; the core and ROM side use slave.
interface instr_fetch_queue_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        instr_valid;

    modport master (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  imem_rdata,
        output imem_en,
        output imem_addr,
        output PC,
        output Instruction,
        output instr_valid
    );

    modport slave (
        output stall,
        output branch_taken,
        output branch_target,
        output imem_rdata,
        input  imem_en,
        input  imem_addr,
        input  PC,
        input  Instruction,
        input  instr_valid
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential ROM reads, buffers {word, pc} pairs in a
// small FIFO and presents a registered head to the core; branches flush everything.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    instr_fetch_queue_if.master        bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_after_pop;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          imem_en_q, imem_en_d;
    logic [31:0]   imem_addr_q, imem_addr_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;

    logic          flush;
    logic          pop;
    logic          push;
    logic [31:0]   issue_pc;
    logic [SW-1:0] slots_used;
    entry_t        push_entry;
    entry_t        head;
    logic          unused_target_lsbs;

    // Word-aligned fetch: the low target bits never reach the address path.
    assign unused_target_lsbs = ^bus.branch_target[1:0];

    // Next-state: pointer/count bookkeeping, issue decision and head preview.
    always_comb begin
        flush      = bus.branch_taken;
        pop        = instr_valid_q & ~bus.stall & ~flush;
        push       = inflight_q & ~flush;
        push_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};

        count_after_pop = count_q - CW'(pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            count_d  = count_after_pop + CW'(push);
        end

        // The strobe seen by the ROM at a flush edge belongs to the old stream.
        inflight_d    = imem_en_q & ~flush;
        inflight_pc_d = imem_addr_q;

        // Reserve a slot for every queued, in-flight and newly strobed word.
        issue_pc    = flush ? {bus.branch_target[31:2], 2'b00} : fetch_pc_q;
        slots_used  = SW'(count_d) + SW'(inflight_d);
        imem_en_d   = slots_used < SW'(DEPTH);
        imem_addr_d = imem_en_d ? issue_pc : imem_addr_q;
        fetch_pc_d  = imem_en_d ? issue_pc + 32'(PC_STEP) : issue_pc;

        // A word landing in an empty queue becomes the head without a RAM round trip.
        if (push && (count_after_pop == '0)) begin
            head = push_entry;
        end else begin
            head = mem_q[rd_ptr_d];
        end

        instr_valid_d = (count_d != '0);
        instr_d       = instr_valid_d ? head.instr : 32'h0000_0000;
        pc_d          = instr_valid_d ? head.pc : pc_q;
    end

    // Control and output registers; reset wins over any redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fetch_pc_q    <= RESET_PC;
            imem_en_q     <= 1'b0;
            imem_addr_q   <= '0;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fetch_pc_q    <= fetch_pc_d;
            imem_en_q     <= imem_en_d;
            imem_addr_q   <= imem_addr_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign bus.imem_en     = imem_en_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.PC          = pc_q;
    assign bus.Instruction = instr_q;
    assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed latency/stall/flush/wrap/reset scenarios plus a
// randomized run against a stream-level model (expected next PC of the delivered stream).
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    instr_fetch_queue_if bus();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    // Synchronous ROM, one cycle read latency.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= rom_word(bus.imem_addr);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves reset released just before the next edge (E0).
    task automatic do_reset();
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0;
        repeat (2) cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_1234;
        repeat (3) cyc();
        vec_cnt++;
        if (bus.imem_en !== 1'b0) begin err_cnt++; $display("FAIL reset_imem_en: got %b want 0", bus.imem_en); end
        vec_cnt++;
        if (bus.imem_addr !== 32'h0) begin err_cnt++; $display("FAIL reset_imem_addr: got %h want 0", bus.imem_addr); end
        vec_cnt++;
        if (bus.PC !== 32'h0) begin err_cnt++; $display("FAIL reset_pc: got %h want 0", bus.PC); end
        vec_cnt++;
        if (bus.Instruction !== 32'h0) begin err_cnt++; $display("FAIL reset_instr: got %h want 0", bus.Instruction); end
        vec_cnt++;
        if (bus.instr_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        bus.branch_taken = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        cyc();
        vec_cnt++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h0) begin
            err_cnt++; $display("FAIL fill_first_issue: got en=%b addr=%h want en=1 addr=0", bus.imem_en, bus.imem_addr);
        end
        vec_cnt++;
        if (bus.instr_valid !== 1'b0 || bus.Instruction !== 32'h0) begin
            err_cnt++; $display("FAIL fill_empty_e0: got v=%b i=%h want v=0 i=0", bus.instr_valid, bus.Instruction);
        end
        cyc();
        vec_cnt++;
        if (bus.instr_valid !== 1'b0) begin err_cnt++; $display("FAIL fill_empty_e1: got v=%b want 0", bus.instr_valid); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            vec_cnt++;
            if (bus.instr_valid !== 1'b1 || bus.PC !== 32'(4 * k) || bus.Instruction !== rom_word(32'(4 * k))) begin
                err_cnt++;
                $display("FAIL fill_seq[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k,
                         bus.instr_valid, bus.PC, bus.Instruction, 32'(4 * k), rom_word(32'(4 * k)));
            end
        end
    endtask

    task automatic test_stall();
        int strobes;
        strobes = 0;
        do_reset();
        repeat (3) begin
            cyc();
            if (bus.imem_en) strobes++;
        end
        bus.stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (bus.imem_en) strobes++;
            vec_cnt++;
            if (bus.instr_valid !== 1'b1 || bus.PC !== 32'h0 || bus.Instruction !== rom_word(32'h0)) begin
                err_cnt++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", k,
                         bus.instr_valid, bus.PC, bus.Instruction, rom_word(32'h0));
            end
        end
        vec_cnt++;
        if (strobes != DEPTH || bus.imem_en !== 1'b0) begin
            err_cnt++; $display("FAIL stall_issue_block: got strobes=%0d en=%b want strobes=%0d en=0", strobes, bus.imem_en, DEPTH);
        end
        bus.stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            vec_cnt++;
            if (bus.instr_valid !== 1'b1 || bus.PC !== 32'(4 * k) || bus.Instruction !== rom_word(32'(4 * k))) begin
                err_cnt++;
                $display("FAIL stall_release[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h", k,
                         bus.instr_valid, bus.PC, bus.Instruction, 32'(4 * k));
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (5) cyc();
        vec_cnt++;
        if (bus.instr_valid !== 1'b1 || bus.PC !== 32'h8) begin
            err_cnt++; $display("FAIL branch_pre_head: got v=%b pc=%h want v=1 pc=8", bus.instr_valid, bus.PC);
        end
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0043;
        cyc();
        bus.branch_taken = 1'b0;
        vec_cnt++;
        if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h40) begin
            err_cnt++;
            $display("FAIL branch_flush_edge: got v=%b en=%b addr=%h want v=0 en=1 addr=40",
                     bus.instr_valid, bus.imem_en, bus.imem_addr);
        end
        cyc();
        vec_cnt++;
        if (bus.instr_valid !== 1'b0) begin err_cnt++; $display("FAIL branch_gap2: got v=%b want 0", bus.instr_valid); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            vec_cnt++;
            if (bus.instr_valid !== 1'b1 || bus.PC !== 32'h40 + 32'(4 * k) || bus.Instruction !== rom_word(32'h40 + 32'(4 * k))) begin
                err_cnt++;
                $display("FAIL branch_seq[%0d]: got v=%b pc=%h i=%h want pc=%h", k,
                         bus.instr_valid, bus.PC, bus.Instruction, 32'h40 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_flush_full();
        do_reset();
        bus.stall = 1'b1;
        repeat (8) cyc();
        vec_cnt++;
        if (bus.imem_en !== 1'b0 || bus.instr_valid !== 1'b1 || bus.PC !== 32'h0) begin
            err_cnt++; $display("FAIL full_state: got en=%b v=%b pc=%h want en=0 v=1 pc=0", bus.imem_en, bus.instr_valid, bus.PC);
        end
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0100;
        cyc();
        bus.branch_taken = 1'b0;
        vec_cnt++;
        if (bus.instr_valid !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 32'h100) begin
            err_cnt++;
            $display("FAIL full_flush: got v=%b en=%b addr=%h want v=0 en=1 addr=100", bus.instr_valid, bus.imem_en, bus.imem_addr);
        end
        cyc();
        cyc();
        vec_cnt++;
        if (bus.instr_valid !== 1'b1 || bus.PC !== 32'h100 || bus.Instruction !== rom_word(32'h100)) begin
            err_cnt++; $display("FAIL full_flush_head: got v=%b pc=%h i=%h want pc=100", bus.instr_valid, bus.PC, bus.Instruction);
        end
        bus.stall = 1'b0;
        cyc();
        vec_cnt++;
        if (bus.instr_valid !== 1'b1 || bus.PC !== 32'h104) begin
            err_cnt++; $display("FAIL full_flush_next: got v=%b pc=%h want pc=104", bus.instr_valid, bus.PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hFFFF_FFF8;
        cyc();
        bus.branch_taken = 1'b0;
        cyc();
        exp_pc = 32'hFFFF_FFF8;
        for (int k = 0; k < 3; k++) begin
            cyc();
            vec_cnt++;
            if (bus.instr_valid !== 1'b1 || bus.PC !== exp_pc || bus.Instruction !== rom_word(exp_pc)) begin
                err_cnt++;
                $display("FAIL wrap[%0d]: got v=%b pc=%h i=%h want pc=%h", k, bus.instr_valid, bus.PC, bus.Instruction, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.stall = 1'b1;
        repeat (5) cyc();
        vec_cnt++;
        if (bus.instr_valid !== 1'b1 || bus.PC !== 32'h0) begin
            err_cnt++; $display("FAIL rstmid_pre: got v=%b pc=%h want v=1 pc=0", bus.instr_valid, bus.PC);
        end
        reset = 1'b0;
        cyc();
        vec_cnt++;
        if (bus.imem_en !== 1'b0 || bus.imem_addr !== 32'h0 || bus.PC !== 32'h0 ||
            bus.Instruction !== 32'h0 || bus.instr_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstmid_zero: got en=%b addr=%h pc=%h i=%h v=%b want all 0",
                     bus.imem_en, bus.imem_addr, bus.PC, bus.Instruction, bus.instr_valid);
        end
        reset = 1'b1;
        bus.stall = 1'b0;
        cyc();
        cyc();
        vec_cnt++;
        if (bus.instr_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_gap: got v=%b want 0", bus.instr_valid); end
        for (int k = 0; k < 2; k++) begin
            cyc();
            vec_cnt++;
            if (bus.instr_valid !== 1'b1 || bus.PC !== 32'(4 * k) || bus.Instruction !== rom_word(32'(4 * k))) begin
                err_cnt++;
                $display("FAIL rstmid_restart[%0d]: got v=%b pc=%h i=%h want pc=%h", k,
                         bus.instr_valid, bus.PC, bus.Instruction, 32'(4 * k));
            end
        end
    endtask

    // Stream model: the head is always the next address of the current stream.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        int blank;
        int inv_run;
        do_reset();
        exp_pc = 32'h0;
        blank = 2;
        inv_run = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (blank > 0) begin
                vec_cnt++;
                if (bus.instr_valid !== 1'b0) begin
                    err_cnt++; $display("FAIL rnd_gap[%0d]: got v=%b want 0", n, bus.instr_valid);
                end
                blank--;
            end else if (bus.instr_valid === 1'b1) begin
                inv_run = 0;
                vec_cnt++;
                if (bus.PC !== exp_pc || bus.Instruction !== rom_word(exp_pc)) begin
                    err_cnt++;
                    $display("FAIL rnd_head[%0d]: got pc=%h i=%h want pc=%h i=%h", n, bus.PC, bus.Instruction, exp_pc, rom_word(exp_pc));
                end
            end else begin
                inv_run++;
                vec_cnt++;
                if (bus.Instruction !== 32'h0 || inv_run > 2) begin
                    err_cnt++;
                    $display("FAIL rnd_empty[%0d]: got i=%h idle=%0d want i=0 idle<=2", n, bus.Instruction, inv_run);
                end
            end
            bus.stall = ($urandom_range(0, 99) < 35);
            bus.branch_taken = ($urandom_range(0, 99) < 4);
            tgt = {16'h0000, 16'($urandom_range(0, 16'hFFFF))};
            bus.branch_target = tgt;
            if (bus.branch_taken) begin
                exp_pc = {tgt[31:2], 2'b00};
                blank = 2;
                inv_run = 0;
            end else if (bus.instr_valid === 1'b1 && !bus.stall) begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        bus.branch_taken = 1'b0;
        bus.stall = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_stall();
        test_branch();
        test_flush_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Upstream neighbour of the `arm` pipelined core.
- Generates fetch addresses, reads a synchronous instruction ROM with 1-cycle read latency, and buffers the returned words with their PCs in a small FIFO.
- Presents the FIFO head to the core as Instruction/PC with a valid flag.
- Handles core stalls and branch redirects, which flush the queue and any read in flight.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising clk edge; 0 = reset.
- stall  input  1  core cannot accept an instruction this cycle.
- branch_taken  input  1  redirect request from the core's execute stage.
- branch_target  input  32  new fetch address; valid while branch_taken=1.
- imem_en  output  1  ROM read strobe.
- imem_addr  output  32  ROM byte address.
- imem_rdata  input  32  ROM data for the address strobed on the previous cycle.
- PC  output  32  PC of the head instruction.
- Instruction  output  32  head instruction word; 32'h0000_0000 (NOP) when empty.
- instr_valid  output  1  head entry is valid.

Behaviour:
- Reset, while reset=0 at a clk edge:
  - fetch_pc = RESET_PC; FIFO pointers and count = 0; inflight = 0.
  - imem_en = 0, imem_addr = 0, PC = 0, Instruction = 0, instr_valid = 0.
  - Reset mid-operation discards all queued and in-flight words.
  - Reset has priority over branch_taken.
- Issue rule:
  - Assert imem_en with imem_addr = fetch_pc when count + inflight < DEPTH (counting this cycle's pop) and branch_taken = 0.
  - On issue: inflight = 1 for the next cycle, and fetch_pc += PC_STEP, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- Return:
  - Every cycle where inflight=1, push {imem_rdata, issued address} into the FIFO, unless a flush occurs the same cycle.
- Pop:
  - Occurs when instr_valid=1 and stall=0.
  - Push and pop in the same cycle leave count unchanged; this is legal at full and at count=1.
- Outputs:
  - Instruction, PC and instr_valid come from the registered FIFO head (no bypass).
  - Head is stable while stall=1.
- Latency:
  - Reset released at edge E0: first issue at E0+1, data returns at E0+2, instr_valid=1 after E0+2.
  - Steady state with stall=0 sustains 1 instruction per cycle.
- Flush, when branch_taken=1:
  - Empty the FIFO; drop the in-flight response; set fetch_pc = branch_target.
  - No issue in the flush cycle; the target is issued the next cycle.
  - instr_valid = 0 for 2 cycles after the flush edge.
  - branch_taken overrides stall and any simultaneous push or pop.
  - branch_target[1:0] is ignored, forced to 0.
- Control states (derivable from count/inflight; an implementation may encode them explicitly):
  - RESET -> FILL (after reset release; issuing, not yet valid).
  - FILL -> RUN (head valid).
  - RUN -> FULL (count = DEPTH, issue blocked).
  - FULL -> RUN (pop frees a slot).
  - Any state -> FILL on branch_taken.
- Empty FIFO: instr_valid=0, Instruction=0, PC holds the last popped value. Stall while empty has no effect.
- Full FIFO with stall=1: no issue and inflight stays 0, so there is never overflow and no response is lost.

Test Plan:
- Reset, ROM word at address k = 32'hE000_0000 | k; release reset, stall=0 -> instr_valid rises 2 cycles later; PC/Instruction sequence 0/E0000000, 4/E0000004, 8/E0000008 on consecutive cycles.
- Hold stall=1 for 10 cycles after the first valid -> head stays PC=0; imem_en drops once count reaches DEPTH (4); on release, PCs 0,4,8,12,16 pop on consecutive cycles with no gap or duplicate.
- Branch: branch_taken=1, branch_target=32'h40 while head PC=8 -> next 2 cycles instr_valid=0; then PC=0x40, 0x44 with matching words; stale words from 0xC and 0x10 never appear.
- Simultaneous branch_taken=1 and stall=1 at full -> flush wins: count=0, imem_addr=0x100 on the following cycle for branch_target=0x100.
- Wrap: branch to 32'hFFFF_FFF8 -> PCs FFFFFFF8, FFFFFFFC, 00000000 in sequence.
- Assert reset=0 for one edge with 3 entries queued and a read in flight -> all outputs 0 next cycle; after release, fetch restarts at RESET_PC with no stale entries.
